p_sequencer: RTL and testbench
==============================

# p_sequencer

Sequential controller that drives the combinational ASCON permutation round `p` (constant addition, substitution layer, linear diffusion) iteratively over a 320-bit state register. It accepts a state and a round count through a start/done handshake, then issues the correct round index each cycle. It returns the permuted state for the p^a (12 rounds) and p^b (6 rounds) phases of the ASCON-128 mode controller. It sits between the mode FSM and a single `p` instance. Optionally it unrolls two instances.

## Interface
Parameters:
- `MAX_ROUNDS`, 12: highest legal round count; round indices run 0..MAX_ROUNDS-1.

Ports:
- `clock_i` in 1: system clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: request; sampled only when `ready_o`=1.
- `state_i` in 320 (`type_state`): input state, captured with an accepted start.
- `nb_rounds_i` in 4: number of rounds to apply, captured with an accepted start.
- `state_o` out 320 (`type_state`): state register contents; holds the result after `done_o`.
- `ready_o` out 1: block can accept a start (IDLE or DONE).
- `busy_o` out 1: permutation in progress (LOAD or RUN).
- `done_o` out 1: one-cycle pulse; `state_o` is the final result in this cycle.
- `round_o` out 4: round index currently presented to `p` (debug/trace).

## Operation
- FSM states are IDLE, LOAD, RUN and DONE. Reset state is IDLE.
- **IDLE**, or **DONE** with `start_i`=1:
  - Capture `state_i` into the state register.
  - Compute n = min(`nb_rounds_i`, MAX_ROUNDS).
  - Set the round counter k=0 and go to LOAD.
- **DONE** without a start: return to IDLE. `state_o` keeps its value.
- **LOAD**: if n=0, go to DONE with the state unchanged. Otherwise go to RUN.
- **RUN**: at each edge, state ← p(state, MAX_ROUNDS−n+k) and k ← k+1. When k reaches n, go to DONE.
- Round index is MAX_ROUNDS−n+k, computed in 4-bit unsigned with no wrap because n ≤ MAX_ROUNDS:
  - n=12 gives indices 0..11.
  - n=6 gives indices 6..11.
- `round_o` shows the index applied at the next edge while in RUN, and 0 otherwise.
- Captured n is held internally. Changing `nb_rounds_i` or `state_i` after acceptance has no effect.
- `start_i` while `busy_o`=1 is ignored and not queued.
- Output decode:
  - `ready_o` = (IDLE | DONE).
  - `busy_o` = (LOAD | RUN).
  - `done_o` = DONE.
  - These are registered-state decodes with no combinational path from inputs.
- Reset, including mid-RUN:
  - FSM goes to IDLE, k=0, state register=0.
  - All outputs go to 0, except `ready_o`=1.
  - No `done_o` is produced for the aborted operation.

## Timing
- Start accepted at edge E0 → LOAD in the cycle after E0.
- With n ≥ 1, RUN cycles follow, and edges E2..E(n+1) apply rounds.
- `done_o`=1 in the cycle after edge E(n+1). Total latency is start edge → done cycle = n+2 cycles:
  - 14 for n=12.
  - 8 for n=6.
  - 2 for n=0.
- Back-to-back: a start accepted in the DONE cycle gives `done_o` pulses n+2 cycles apart, with no idle gap.
- `state_o` is stable from `done_o` until the next accepted start's capture edge.
- One `p` evaluation per cycle; the critical path is a single round.

## Configuration
- `P_SEQ_UNROLL2_EN` defined: two `p` instances are chained per cycle.
  - Each RUN edge applies indices r and r+1, and k advances by 2.
  - If one round remains, only the first instance's output is registered and k advances by 1.
  - RUN lasts ceil(n/2) cycles, so latency is ceil(n/2)+2: 8 for n=12, 5 for n=6.
  - `round_o` shows the first index of the pair.
- Undefined: one instance, one round per cycle, timing as above.

## Test plan
- n=12, arbitrary state X, start at cycle 0:
  - `done_o` occurs only in cycle 14.
  - `round_o` shows 0..11 in RUN.
  - `state_o` equals the software model p^12(X), checked against the ASCON-128 initialization vector for key=0, nonce=0.
- n=6, start at cycle 0:
  - `round_o` shows 6..11.
  - `done_o` in cycle 8.
  - `state_o` equals model p^6.
- n=0 → `done_o` in cycle 2 with `state_o`=`state_i`. n=15 → identical behaviour and result to n=12.
- `start_i` pulsed at cycle 5 during an n=12 run → ignored; exactly one `done_o` at cycle 14.
- Back-to-back:
  - Start held high from cycle 0 → `done_o` at cycles 14 and 28 (n=12).
  - The second result equals p^12 of the second captured `state_i`.
- `reset_i` asserted asynchronously mid-cycle during round 4 → the following signals go to 0 immediately, without waiting for an edge:
  - `busy_o`
  - `state_o`
  - `round_o`
  - `done_o`
  
  After release, `ready_o`=1 and a new n=6 start completes normally. Repeat all cases with `P_SEQ_UNROLL2_EN`, using latencies 8/5/2.

Source files
------------

// File: rtl/p_sequencer_if.sv
// rtl/p_sequencer_if.sv - start/done handshake and state bus between the mode FSM and p_sequencer
interface p_sequencer_if;
    logic         start_i;
    logic [319:0] state_i;
    logic [3:0]   nb_rounds_i;
    logic [319:0] state_o;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   round_o;

    // mode FSM side: issues requests, consumes results
    modport master (
        output start_i, state_i, nb_rounds_i,
        input  state_o, ready_o, busy_o, done_o, round_o
    );

    // sequencer side
    modport slave (
        input  start_i, state_i, nb_rounds_i,
        output state_o, ready_o, busy_o, done_o, round_o
    );
endinterface

// File: rtl/p_sequencer.sv
// rtl/p_sequencer.sv - iterative ASCON p round sequencer; define P_SEQ_UNROLL2_EN to chain two rounds per cycle
module p_sequencer #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic           clock_i,
    input  logic           reset_i,
    p_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] MAX_R4 = 4'(MAX_ROUNDS);

    logic [1:0]   r_fsm;
    logic [3:0]   r_k;
    logic [3:0]   r_n;
    logic [319:0] r_st;

    logic [3:0]   w_n_in;
    logic [3:0]   w_round;
    logic [319:0] w_next;
    logic [3:0]   w_k_next;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // one ASCON round: constant addition, 5-bit S-box layer, linear diffusion
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'd0, 4'hf - r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Clamp requested rounds; shorter runs use the tail of the schedule so
    // p^6 sees indices 6..11 exactly like the ASCON reference.
    assign w_n_in  = (bus.nb_rounds_i > MAX_R4) ? MAX_R4 : bus.nb_rounds_i;
    assign w_round = MAX_R4 - r_n + r_k;

`ifdef P_SEQ_UNROLL2_EN
    logic [319:0] w_p1;
    logic [319:0] w_p2;
    logic         w_two;

    // Two chained rounds; the second output is dropped when only one round is left.
    assign w_p1     = ascon_round(r_st, w_round);
    assign w_p2     = ascon_round(w_p1, w_round + 4'd1);
    assign w_two    = (r_n - r_k) >= 4'd2;
    assign w_next   = w_two ? w_p2 : w_p1;
    assign w_k_next = r_k + (w_two ? 4'd2 : 4'd1);
`else
    assign w_next   = ascon_round(r_st, w_round);
    assign w_k_next = r_k + 4'd1;
`endif

    // Control FSM, round counter and state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm <= S_IDLE;
            r_k   <= 4'd0;
            r_n   <= 4'd0;
            r_st  <= '0;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        r_st  <= bus.state_i;
                        r_n   <= w_n_in;
                        r_k   <= 4'd0;
                        r_fsm <= S_LOAD;
                    end else begin
                        r_fsm <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_fsm <= (r_n == 4'd0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    r_st <= w_next;
                    r_k  <= w_k_next;
                    if (w_k_next == r_n) begin
                        r_fsm <= S_DONE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign bus.state_o = r_st;
    assign bus.ready_o = (r_fsm == S_IDLE) || (r_fsm == S_DONE);
    assign bus.busy_o  = (r_fsm == S_LOAD) || (r_fsm == S_RUN);
    assign bus.done_o  = (r_fsm == S_DONE);
    assign bus.round_o = (r_fsm == S_RUN) ? w_round : 4'd0;

endmodule

// File: tb/tb_p_sequencer.sv
// tb/tb_p_sequencer.sv - scoreboard bench for p_sequencer (both P_SEQ_UNROLL2_EN builds)
module tb_p_sequencer;

    logic clock_i;
    logic reset_i;
    p_sequencer_if bus();

    p_sequencer #(.MAX_ROUNDS(12)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [319:0] exp;
        int           a;
        int           n;
        int           lat;
    } ent_t;

    ent_t         q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           n_acc = 0;
    logic [319:0] last_result = '0;

    localparam logic [319:0] IV_STATE = {64'h80400c0600000000, 256'd0};

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference round: S-box applied column-wise through its lookup table.
    function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
        logic [4:0]  sbox [32];
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v, o;
        logic [127:0] d;
        int rot [5][2];
        sbox = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        rot = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
        for (int j = 0; j < 64; j++) begin
            v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            o = sbox[v];
            for (int w = 0; w < 5; w++) y[w][j] = o[4 - w];
        end
        for (int w = 0; w < 5; w++) begin
            d = {y[w], y[w]};
            x[w] = y[w] ^ d[rot[w][0] +: 64] ^ d[rot[w][1] +: 64];
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int n);
        logic [319:0] t = s;
        for (int i = 0; i < n; i++) t = m_round(t, 12 - n + i);
        return t;
    endfunction

    function automatic int lat_of(input int n);
`ifdef P_SEQ_UNROLL2_EN
        return (n + 1) / 2 + 2;
`else
        return n + 2;
`endif
    endfunction

    function automatic int step_of();
`ifdef P_SEQ_UNROLL2_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
        return t;
    endfunction

    task automatic monitor();
        int   e;
        logic exp_busy, exp_done;
        logic [3:0] exp_round;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_round = 4'd0;
        if (q.size() != 0) begin
            e = cyc - q[0].a + 1;
            exp_busy = (e < q[0].lat);
            exp_done = (e == q[0].lat);
            if (e >= 2 && e < q[0].lat)
                exp_round = 4'(12 - q[0].n + step_of() * (e - 2));
        end
        chk("busy",  bus.busy_o,  exp_busy);
        chk("ready", bus.ready_o, !exp_busy);
        chk("done",  bus.done_o,  exp_done);
        chk("round", bus.round_o, exp_round);
        if (exp_done) begin
            chk("result", bus.state_o, q[0].exp);
            last_result = q[0].exp;
            void'(q.pop_front());
        end else if (q.size() == 0) begin
            chk("hold", bus.state_o, last_result);
        end
    endtask

    // One clock: predict acceptance at the edge, then check at the falling edge.
    task automatic tick();
        int n_eff;
        ent_t en;
        @(posedge clock_i);
        cyc++;
        if (!reset_i && bus.start_i && q.size() == 0) begin
            n_eff  = (int'(bus.nb_rounds_i) > 12) ? 12 : int'(bus.nb_rounds_i);
            en.exp = m_perm(bus.state_i, n_eff);
            en.a   = cyc;
            en.n   = n_eff;
            en.lat = lat_of(n_eff);
            q.push_back(en);
            n_acc++;
        end
        @(negedge clock_i);
        monitor();
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        chk("timeout", 320'(q.size()), 320'd0);
    endtask

    task automatic start_op(input logic [319:0] s, input logic [3:0] nb);
        bus.state_i     = s;
        bus.nb_rounds_i = nb;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        bus.state_i     = rand320();
        bus.nb_rounds_i = 4'($urandom_range(0, 15));
    endtask

    initial begin
        reset_i         = 1'b1;
        bus.start_i     = 1'b0;
        bus.state_i     = '0;
        bus.nb_rounds_i = 4'd0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();

        // p^12 of the ASCON-128 IV state, then p^6, p^0 and a clamped 15
        start_op(IV_STATE, 4'd12);
        run_idle(40);
        tick();
        start_op(rand320(), 4'd6);
        run_idle(40);
        start_op(rand320(), 4'd0);
        run_idle(40);
        tick();
        start_op(IV_STATE, 4'd15);
        run_idle(40);
        start_op(rand320(), 4'd5);
        run_idle(40);

        // start pulse during a run must be ignored
        start_op(rand320(), 4'd12);
        for (int i = 0; i < 4; i++) tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_idle(40);

        // back-to-back with start held high; second capture gets a new state
        n_acc = 0;
        bus.state_i     = rand320();
        bus.nb_rounds_i = 4'd12;
        bus.start_i     = 1'b1;
        tick();
        bus.state_i = rand320();
        for (int i = 0; i < 60 && n_acc < 2; i++) tick();
        bus.start_i = 1'b0;
        chk("b2b_accepts", 320'(n_acc), 320'd2);
        run_idle(40);

        // asynchronous reset in the middle of a run
        start_op(rand320(), 4'd12);
        for (int i = 0; i < (step_of() == 2 ? 3 : 5); i++) tick();
        chk("pre_rst_round", bus.round_o, 4'd4);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rst_busy",  bus.busy_o,  1'b0);
        chk("rst_state", bus.state_o, 320'd0);
        chk("rst_round", bus.round_o, 4'd0);
        chk("rst_done",  bus.done_o,  1'b0);
        chk("rst_ready", bus.ready_o, 1'b1);
        q.delete();
        last_result = '0;
        tick();
        reset_i = 1'b0;
        tick();
        start_op(rand320(), 4'd6);
        run_idle(40);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
